// File: rtl/wordcount_batch_ctrl.sv
// Batch sequencer for the search_and_add wordcount datapath.
// Streams keys into the datapath FIFO, kicks passes and reports batch stats.
module wordcount_batch_ctrl #(
    parameter int unsigned BATCH_SIZE = 256,
    parameter int unsigned TIMEOUT    = 64,
    parameter int unsigned START_WAIT = 15,
    parameter logic [31:0] INC        = 32'd1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [127:0] in_key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    input  logic         sa_ready,
    output logic [159:0] sa_din,
    output logic         sa_we,
    input  logic         sa_full,
    output logic         sa_kick,
    input  logic         sa_busy,
    input  logic         sa_accum_we,
    output logic         batch_done,
    output logic [31:0]  batch_words,
    output logic [31:0]  batch_accums,
    output logic [31:0]  batches_total,
    output logic         err_no_start,
    output logic         idle
);

    localparam logic [2:0] S_INIT   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_KICK   = 3'd2;
    localparam logic [2:0] S_WSTART = 3'd3;
    localparam logic [2:0] S_WEND   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [16:0] BS    = 17'(BATCH_SIZE);
    localparam logic [31:0] TO_M1 = 32'(TIMEOUT) - 32'd1;
    localparam logic [31:0] SW_M1 = 32'(START_WAIT) - 32'd1;
    localparam bit          TO_EN = (TIMEOUT > 0);

    logic [2:0]  state;
    logic [16:0] wcnt;
    logic [16:0] wnext;
    logic [31:0] icnt;
    logic [31:0] scnt;
    logic [31:0] acnt;
    logic [31:0] acnt_inc;
    logic        in_fill;
    logic        xfer;
    logic        kick;

    assign in_fill  = (state == S_FILL);
    assign in_ready = reset & in_fill & sa_ready & ~sa_full & (wcnt < BS);
    assign xfer     = in_valid & in_ready;
    assign sa_we    = xfer;
    assign sa_din   = {in_key, INC};
    assign wnext    = wcnt + {16'd0, xfer};

    // The timeout only fires on a quiet cycle; a transfer restarts the idle count.
    assign kick = in_fill & ((wnext == BS)
                | (flush & (wnext != 17'd0))
                | (TO_EN & ~xfer & (wcnt != 17'd0) & (icnt == TO_M1)));

    assign sa_kick    = (state == S_KICK);
    assign batch_done = (state == S_DONE);
    assign idle       = in_fill & (wcnt == 17'd0);

    // Saturating count of result writes seen during the pass.
    assign acnt_inc = acnt + {31'd0, sa_accum_we & (acnt != '1)};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= S_INIT;
            wcnt          <= '0;
            icnt          <= '0;
            scnt          <= '0;
            acnt          <= '0;
            batch_words   <= '0;
            batch_accums  <= '0;
            batches_total <= '0;
            err_no_start  <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    if (sa_ready) state <= S_FILL;
                end
                S_FILL: begin
                    wcnt <= wnext;
                    if (xfer || wcnt == 17'd0) icnt <= '0;
                    else                       icnt <= icnt + 32'd1;
                    if (kick) state <= S_KICK;
                end
                S_KICK: begin
                    acnt  <= {31'd0, sa_accum_we};
                    scnt  <= '0;
                    state <= S_WSTART;
                end
                S_WSTART: begin
                    acnt <= acnt_inc;
                    if (sa_busy) begin
                        state <= S_WEND;
                    end else if (scnt == SW_M1) begin
                        err_no_start <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        scnt <= scnt + 32'd1;
                    end
                end
                S_WEND: begin
                    acnt <= acnt_inc;
                    if (!sa_busy) state <= S_DONE;
                end
                S_DONE: begin
                    batch_words   <= 32'(wcnt);
                    batch_accums  <= acnt;
                    batches_total <= batches_total + 32'd1;
                    wcnt          <= '0;
                    icnt          <= '0;
                    state         <= S_FILL;
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_wordcount_batch_ctrl.sv
// Directed bench for wordcount_batch_ctrl (BATCH_SIZE=4, TIMEOUT=8).
module tb_wordcount_batch_ctrl;

    logic         clk;
    logic         reset;
    logic [127:0] in_key;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic         sa_ready;
    logic [159:0] sa_din;
    logic         sa_we;
    logic         sa_full;
    logic         sa_kick;
    logic         sa_busy;
    logic         sa_accum_we;
    logic         batch_done;
    logic [31:0]  batch_words;
    logic [31:0]  batch_accums;
    logic [31:0]  batches_total;
    logic         err_no_start;
    logic         idle;

    int checks;
    int failures;
    logic [127:0] keys [0:10];

    wordcount_batch_ctrl #(
        .BATCH_SIZE(4),
        .TIMEOUT(8),
        .START_WAIT(15),
        .INC(32'd1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_key(in_key),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .flush(flush),
        .sa_ready(sa_ready),
        .sa_din(sa_din),
        .sa_we(sa_we),
        .sa_full(sa_full),
        .sa_kick(sa_kick),
        .sa_busy(sa_busy),
        .sa_accum_we(sa_accum_we),
        .batch_done(batch_done),
        .batch_words(batch_words),
        .batch_accums(batch_accums),
        .batches_total(batches_total),
        .err_no_start(err_no_start),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [159:0] obs,
                       input logic [159:0] want);
        checks++;
        assert (obs === want) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Called in the KICK cycle: busy for n_busy cycles, accum pulses on
    // cycles 1..n_acc, then busy drops and DONE follows one cycle later.
    task automatic run_pass(input int n_busy, input int n_acc);
        for (int c = 0; c < n_busy; c++) begin
            sa_busy     = 1'b1;
            sa_accum_we = (c >= 1 && c <= n_acc);
            #1;
            chk("pass_no_done", batch_done, 0);
            chk("pass_no_ready", in_ready, 0);
            chk("pass_no_we", sa_we, 0);
            step;
        end
        sa_busy     = 1'b0;
        sa_accum_we = 1'b0;
        #1;
        chk("pass_last_no_done", batch_done, 0);
        step;
        chk("pass_done", batch_done, 1);
        step;
        chk("pass_done_once", batch_done, 0);
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        keys[0]  = 128'hDEADBEEF_ABADCAFE_FEFEFEFE_34343434;
        keys[1]  = 128'h11111111_22222222_33333333_44444444;
        keys[2]  = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        keys[3]  = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        keys[4]  = 128'h00000000_00000000_00000000_00000001;
        keys[5]  = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF;
        keys[6]  = 128'hC0FFEE00_C0FFEE01_C0FFEE02_C0FFEE03;
        keys[7]  = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
        keys[8]  = 128'h80000000_00000000_00000000_00000000;
        keys[9]  = 128'h600DF00D_BAADF00D_DEADC0DE_FACEB00C;
        keys[10] = 128'h77777777_88888888_99999999_AAAAAAAA;
        reset       = 1'b0;
        sa_ready    = 1'b0;
        in_key      = '0;
        in_valid    = 1'b1;
        flush       = 1'b0;
        sa_full     = 1'b0;
        sa_busy     = 1'b0;
        sa_accum_we = 1'b0;

        repeat (3) step;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_sa_we", sa_we, 0);
        chk("rst_sa_kick", sa_kick, 0);
        chk("rst_batch_done", batch_done, 0);
        chk("rst_batch_words", batch_words, 0);
        chk("rst_batch_accums", batch_accums, 0);
        chk("rst_batches_total", batches_total, 0);
        chk("rst_err", err_no_start, 0);
        chk("rst_idle", idle, 0);

        in_valid = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step;
            chk("init_no_ready", in_ready, 0);
            chk("init_not_idle", idle, 0);
        end
        sa_ready = 1'b1;
        #1;
        chk("init_ready_lag", in_ready, 0);
        step;
        chk("fill_ready", in_ready, 1);
        chk("fill_idle", idle, 1);

        // Batch-full kick after four back-to-back keys.
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_key = keys[i];
            #1;
            chk("full_we", sa_we, 1);
            chk("full_din", sa_din, {keys[i], 32'd1});
            chk("full_no_kick", sa_kick, 0);
            step;
        end
        in_key = keys[4];
        #1;
        chk("full_kick", sa_kick, 1);
        chk("kick_no_ready", in_ready, 0);
        chk("kick_no_we", sa_we, 0);
        run_pass(10, 3);
        chk("b1_words", batch_words, 4);
        chk("b1_accums", batch_accums, 3);
        chk("b1_total", batches_total, 1);
        chk("b2_k4_we", sa_we, 1);
        chk("b2_k4_din", sa_din, {keys[4], 32'd1});
        step;
        in_key = keys[5];
        #1;
        chk("b2_k5_we", sa_we, 1);
        step;
        in_valid = 1'b0;

        // Idle timeout: kick lands eight edges after the last transfer edge.
        chk("to_no_kick0", sa_kick, 0);
        for (int k = 1; k <= 7; k++) begin
            step;
            chk("to_early", sa_kick, 0);
        end
        step;
        chk("to_kick", sa_kick, 1);
        run_pass(3, 0);
        chk("b2_words", batch_words, 2);
        chk("b2_accums", batch_accums, 0);
        chk("b2_total", batches_total, 2);

        // Flush on the third cycle after two keys.
        in_valid = 1'b1;
        in_key   = keys[6];
        step;
        in_key = keys[7];
        step;
        in_valid = 1'b0;
        flush    = 1'b1;
        #1;
        chk("fl_no_kick_yet", sa_kick, 0);
        step;
        flush = 1'b0;
        chk("fl_kick", sa_kick, 1);
        run_pass(2, 1);
        chk("b3_words", batch_words, 2);
        chk("b3_accums", batch_accums, 1);
        chk("b3_total", batches_total, 3);

        // Flush on an empty batch is ignored.
        flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step;
            chk("fl_empty_no_kick", sa_kick, 0);
            chk("fl_empty_idle", idle, 1);
        end
        in_valid = 1'b1;
        in_key   = keys[8];
        #1;
        chk("fl_xfer_we", sa_we, 1);
        step;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("fl_xfer_kick", sa_kick, 1);
        run_pass(2, 0);
        chk("b4_words", batch_words, 1);
        chk("b4_total", batches_total, 4);

        // Backpressure from a full datapath FIFO.
        sa_full  = 1'b1;
        in_valid = 1'b1;
        in_key   = keys[9];
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_no_ready", in_ready, 0);
            chk("bp_no_we", sa_we, 0);
            step;
        end
        sa_full = 1'b0;
        #1;
        chk("bp_ready", in_ready, 1);
        chk("bp_we", sa_we, 1);
        chk("bp_din", sa_din, {keys[9], 32'd1});
        step;
        in_valid = 1'b0;
        flush    = 1'b1;
        step;
        flush = 1'b0;
        chk("ns_kick", sa_kick, 1);

        // sa_busy never rises: error and DONE fifteen cycles into WAIT_START.
        step;
        chk("ns_no_done0", batch_done, 0);
        for (int k = 1; k <= 14; k++) begin
            step;
            chk("ns_no_done", batch_done, 0);
            chk("ns_no_err", err_no_start, 0);
        end
        step;
        chk("ns_done", batch_done, 1);
        chk("ns_err", err_no_start, 1);
        step;
        chk("ns_words", batch_words, 1);
        chk("ns_total", batches_total, 5);
        chk("ns_err_sticky", err_no_start, 1);

        // Reset during WAIT_END abandons the batch.
        in_valid = 1'b1;
        in_key   = keys[10];
        #1;
        chk("rm_we", sa_we, 1);
        step;
        in_valid = 1'b0;
        flush    = 1'b1;
        step;
        flush   = 1'b0;
        sa_busy = 1'b1;
        chk("rm_kick", sa_kick, 1);
        step;
        step;
        step;
        reset = 1'b0;
        step;
        chk("rm_no_done", batch_done, 0);
        chk("rm_total", batches_total, 0);
        chk("rm_err_clr", err_no_start, 0);
        chk("rm_init_ready", in_ready, 0);
        chk("rm_init_idle", idle, 0);
        sa_busy = 1'b0;
        reset   = 1'b1;
        #1;
        chk("rm_init_hold", in_ready, 0);
        step;
        chk("rm_fill_idle", idle, 1);
        chk("rm_fill_no_done", batch_done, 0);
        chk("rm_fill_total", batches_total, 0);
        chk("rm_fill_words", batch_words, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wordcount_batch_ctrl.md
Name: wordcount_batch_ctrl

Overview:
- Sequences the search_and_add wordcount datapath.
- Accepts a stream of 128-bit word keys and forwards each one to the datapath input FIFO as a {key, increment} record.
- Decides when to kick a search-and-accumulate pass: batch full, idle timeout, or explicit flush.
- Waits for the pass to complete and reports per-batch statistics. Sits between the word tokenizer and search_and_add.

Parameters:
- BATCH_SIZE, 256: maximum words per batch; reaching it forces a kick (1..2^16).
- TIMEOUT, 64: idle cycles with a non-empty batch before a forced kick; 0 disables the timeout.
- START_WAIT, 15: cycles after kick within which sa_busy must rise.
- INC, 1: 32-bit increment value appended to every key.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- in_key  in  128  word key from tokenizer
- in_valid  in  1  in_key valid
- in_ready  out  1  controller accepts in_key this cycle
- flush  in  1  request to kick any pending non-empty batch
- sa_ready  in  1  search_and_add initialised
- sa_din  out  160  {in_key[127:0], INC[31:0]} to search_and_add din
- sa_we  out  1  write strobe to search_and_add
- sa_full  in  1  search_and_add input FIFO full
- sa_kick  out  1  start pulse to search_and_add
- sa_busy  in  1  search_and_add pass in progress
- sa_accum_we  in  1  search_and_add result-write strobe (one per accumulated entry)
- batch_done  out  1  one-cycle pulse at end of each batch
- batch_words  out  32  words in last completed batch
- batch_accums  out  32  sa_accum_we pulses seen during last batch pass
- batches_total  out  32  completed batches since reset, wraps at 2^32
- err_no_start  out  1  sticky: sa_busy never rose within START_WAIT
- idle  out  1  high in FILL with empty batch

Behaviour:
- Reset (reset=0 at a clk edge):
  - State goes to INIT.
  - All counters and outputs are 0: in_ready, sa_we, sa_kick, batch_done, batch_words, batch_accums, batches_total, err_no_start, idle.
  - sa_din is don't-care.
  - Reset asserted mid-pass abandons the batch. No batch_done is issued.
- INIT: wait for sa_ready=1, then go to FILL on the next cycle.
- FILL:
  - in_ready = sa_ready & ~sa_full & (wcnt < BATCH_SIZE), combinational.
  - Transfer occurs when in_valid & in_ready. On a transfer, sa_we=1 and sa_din={in_key, INC} in the same cycle (combinational pass-through), and wcnt increments.
  - sa_we is never high when sa_full=1 or outside FILL.
  - Idle counter: cleared on each transfer or when wcnt=0; otherwise increments.
  - Go to KICK when any of the following holds (evaluated on registered wcnt, including a same-cycle transfer):
    - wcnt == BATCH_SIZE;
    - flush=1 and wcnt>0 (or a transfer occurs this cycle);
    - TIMEOUT>0 and idle counter == TIMEOUT-1 with wcnt>0.
  - flush with an empty batch and no transfer is ignored.
  - A word accepted in the same cycle as a kick decision belongs to the current batch.
  - sa_ready falling in FILL only blocks in_ready; the state is held.
- KICK:
  - sa_kick=1 for exactly one cycle; in_ready=0.
  - acnt cleared; start-wait counter cleared.
  - Go to WAIT_START.
- WAIT_START:
  - If sa_busy=1, go to WAIT_END.
  - Else if start-wait counter == START_WAIT-1, set err_no_start and go to DONE.
  - Otherwise increment the start-wait counter.
- WAIT_END: stay until sa_busy=0, then go to DONE.
- sa_accum_we counting: counted into acnt in KICK, WAIT_START and WAIT_END. acnt saturates at 2^32-1.
- DONE, one cycle:
  - batch_done=1.
  - batch_words<=wcnt, batch_accums<=acnt.
  - batches_total+1; wcnt and idle counter cleared.
  - Go to FILL.
- Latency:
  - Kick decision in FILL at cycle N gives sa_kick at N+1.
  - batch_done comes one cycle after the sa_busy falling edge is sampled.
- idle = (state==FILL) & (wcnt==0).

Test Plan:
- Release reset with sa_ready low for 5 cycles, then high -> in_ready stays 0 until 1 cycle after sa_ready=1; all outputs 0 during reset.
- BATCH_SIZE=4, stream 6 keys back-to-back (first 0xDEADBEEF_ABADCAFE_FEFEFEFE_34343434) -> 4 sa_we pulses, with sa_din[159:32] of the first equal to that key and sa_din[31:0]=1; sa_kick one cycle later; model busy for 10 cycles with 3 accum_we -> batch_done, batch_words=4, batch_accums=3, batches_total=1; remaining 2 keys accepted after DONE.
- Send 2 keys then stop, TIMEOUT=8 -> sa_kick exactly 8 cycles after the last transfer; batch_words=2. Same test with flush=1 on cycle 3 -> kick at cycle 4.
- Assert flush with empty batch -> no sa_kick. Assert flush together with a key transfer -> kick next cycle, batch_words=1.
- Hold sa_full=1 with in_valid=1 for 5 cycles -> in_ready=0 and sa_we=0 throughout; the word transfers on the first cycle after sa_full=0.
- Kick with sa_busy never rising, START_WAIT=15 -> err_no_start=1 and batch_done 15 cycles after WAIT_START entry, error sticky; reset during WAIT_END -> INIT, no batch_done, batches_total=0.
